// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for the FFT lane schedulers.
package fft_ctrl_pkg;

   localparam int NUM_REQ    = 4;
   localparam int SEL_W      = 2;
   localparam int DW_DEFAULT = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Beat counter width: enough for 0..burst-1, never narrower than one bit.
   function automatic int cnt_width(input int burst);
      return (burst <= 2) ? 1 : $clog2(burst);
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set request at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
   import fft_ctrl_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   logic [SEL_W-1:0] cand;

   // Scan from the farthest offset down so the offset closest to ptr wins.
   always_comb begin
      idx  = ptr;
      cand = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/fft_mux_arbiter.sv
// Round-robin burst arbiter for the shared 4:1 sample MUX, with a 1-deep
// registered valid/ready output stage.
module fft_mux_arbiter
   import fft_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*DW-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [SEL_W-1:0]      sel,
   output logic                  out_valid,
   output logic [DW-1:0]         out_data,
   output logic [SEL_W-1:0]      out_src,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int            CW        = cnt_width(BURST);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

   state_e           state_q;
   logic [SEL_W-1:0] ptr_q;
   logic [SEL_W-1:0] gnt_q;
   logic [CW-1:0]    beat_q;

   logic             valid_q;
   logic [DW-1:0]    data_q;
   logic [SEL_W-1:0] src_q;
   logic             last_q;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic [DW-1:0]    lane_data [NUM_REQ];
   logic [DW-1:0]    gnt_data;
   logic             granted;
   logic             can_load;
   logic             xfer;
   logic             is_last;

   // Unpack the flat sample bus into per-lane words.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign lane_data[gi] = req_data[gi*DW +: DW];
      end
   endgenerate

   rr_pick4 u_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign granted  = (state_q == GRANT);
   assign can_load = !valid_q || out_ready;
   assign gnt_data = lane_data[gnt_q];
   assign xfer     = granted && req_valid[gnt_q] && can_load;
   assign is_last  = (beat_q == LAST_BEAT);

   assign sel       = gnt_q;
   assign busy      = granted;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_last  = last_q;

   // Only the granted lane may see ready, and only when the output slot can take a beat.
   always_comb begin
      req_ready = '0;
      if (granted && can_load) begin
         req_ready[gnt_q] = 1'b1;
      end
   end

   // Arbitration FSM: one cycle to pick, then hold the grant for a full atomic burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         beat_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_q   <= pick_idx;
                  beat_q  <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  if (is_last) begin
                     beat_q  <= '0;
                     ptr_q   <= gnt_q + SEL_W'(1);
                     state_q <= IDLE;
                  end else begin
                     beat_q <= beat_q + CW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output slot: load on a transfer (even while draining), otherwise empty on drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
         last_q  <= 1'b0;
      end else if (xfer) begin
         valid_q <= 1'b1;
         data_q  <= gnt_data;
         src_q   <= gnt_q;
         last_q  <= is_last;
      end else if (valid_q && out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_mux_arbiter.sv
// Randomized and directed bench for fft_mux_arbiter against a lane/burst reference model.
module tb_fft_mux_arbiter;

   localparam int DW    = 16;
   localparam int BURST = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [4*DW-1:0] req_data;
   logic [3:0]    req_ready;
   logic [1:0]    sel;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    out_src;
   logic          out_last;
   logic          out_ready;
   logic          busy;

   logic [3:0]    b1_req_valid;
   logic [4*DW-1:0] b1_req_data;
   logic [3:0]    b1_req_ready;
   logic [1:0]    b1_sel;
   logic          b1_out_valid;
   logic [DW-1:0] b1_out_data;
   logic [1:0]    b1_out_src;
   logic          b1_out_last;
   logic          b1_out_ready;
   logic          b1_busy;

   always #5 clk = ~clk;

   fft_mux_arbiter #(.DW(DW), .BURST(BURST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy)
   );

   fft_mux_arbiter #(.DW(DW), .BURST(1)) u_dut_b1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (b1_req_valid),
      .req_data  (b1_req_data),
      .req_ready (b1_req_ready),
      .sel       (b1_sel),
      .out_valid (b1_out_valid),
      .out_data  (b1_out_data),
      .out_src   (b1_out_src),
      .out_last  (b1_out_last),
      .out_ready (b1_out_ready),
      .busy      (b1_busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Stimulus state: per-lane pending beat count and the sample currently presented.
   logic [15:0] lane_val  [4];
   int          lane_left [4];
   int          gate_pct  = 100;
   int          ready_pct = 100;
   int          stall_cnt = 0;
   bit          rand_data = 0;

   // Reference model: which lane owns the MUX, how far into its burst, who is next in turn,
   // and what sits in the output slot.
   bit          m_serving;
   int          m_lane;
   int          m_beats;
   int          m_prio;
   bit          m_ov;
   logic [15:0] m_od;
   int          m_os;
   bit          m_ol;

   typedef struct {
      int          src;
      logic [15:0] data;
      bit          last;
   } obs_t;
   obs_t obs_q[$];
   int   step_no;
   int   first_valid_step;

   task automatic model_reset();
      m_serving = 0;
      m_lane    = 0;
      m_beats   = 0;
      m_prio    = 0;
      m_ov      = 0;
      m_od      = '0;
      m_os      = 0;
      m_ol      = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = (lane_left[i] > 0) && ($urandom_range(99) < gate_pct);
         req_data[i*DW +: DW] = lane_val[i];
      end
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else begin
         out_ready = ($urandom_range(99) < ready_pct);
      end
   endtask

   // One clock: compare at the falling edge, advance the model, then drive new inputs.
   task automatic step();
      logic [3:0] exp_rdy;
      bit         xfer;
      bit         was_serving;
      @(negedge clk);
      step_no++;
      exp_rdy = '0;
      if (m_serving && (!m_ov || out_ready)) exp_rdy[m_lane] = 1'b1;
      check("busy",      busy,      m_serving);
      check("sel",       sel,       m_lane);
      check("req_ready", req_ready, exp_rdy);
      check("out_valid", out_valid, m_ov);
      check("out_data",  out_data,  m_od);
      check("out_src",   out_src,   m_os);
      check("out_last",  out_last,  m_ol);
      if (out_valid && first_valid_step < 0) first_valid_step = step_no;
      if (out_valid && out_ready) obs_q.push_back('{int'(out_src), out_data, out_last});

      was_serving = m_serving;
      xfer = m_serving && req_valid[m_lane] && (!m_ov || out_ready);
      if (xfer) begin
         m_ov = 1;
         m_od = lane_val[m_lane];
         m_os = m_lane;
         m_ol = (m_beats == BURST - 1);
         lane_left[m_lane]--;
         lane_val[m_lane] = rand_data ? 16'($urandom) : lane_val[m_lane] + 16'd1;
         m_beats++;
         if (m_beats == BURST) begin
            m_serving = 0;
            m_prio    = (m_lane + 1) % 4;
            m_beats   = 0;
         end
      end else if (m_ov && out_ready) begin
         m_ov = 0;
      end
      if (!was_serving && req_valid != 4'b0) begin
         for (int k = 0; k < 4; k++) begin
            if (req_valid[(m_prio + k) % 4]) begin
               m_lane = (m_prio + k) % 4;
               break;
            end
         end
         m_serving = 1;
         m_beats   = 0;
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < 4; i++) lane_left[i] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_lanes();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_srcs(input string tag, input int n_each, input int l0, input int l1);
      check({tag, "_count"}, obs_q.size(), 2 * n_each);
      for (int k = 0; k < obs_q.size() && k < 2 * n_each; k++) begin
         check({tag, "_src"},  obs_q[k].src,  (k < n_each) ? l0 : l1);
         check({tag, "_last"}, obs_q[k].last, (k % n_each) == n_each - 1);
      end
   endtask

   initial begin
      int n;
      int b1_seen;
      int b1_src [$];
      rst_n        = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      out_ready    = 1'b0;
      b1_req_valid = '0;
      b1_req_data  = '0;
      b1_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         lane_val[i]  = '0;
         lane_left[i] = 0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy",      busy,      0);
      check("rst_sel",       sel,       0);
      check("rst_req_ready", req_ready, 0);
      check("rst_out_data",  out_data,  0);
      rst_n = 1'b1;

      // Single requester 2, samples 100..103.
      lane_val[2] = 16'd100; lane_left[2] = 4;
      obs_q.delete(); step_no = 0; first_valid_step = -1;
      drive();
      repeat (10) step();
      check("single_latency", first_valid_step, 3);
      check("single_count", obs_q.size(), 4);
      for (int k = 0; k < obs_q.size() && k < 4; k++) begin
         check("single_src",  obs_q[k].src,  2);
         check("single_data", obs_q[k].data, 100 + k);
         check("single_last", obs_q[k].last, k == 3);
      end

      // Rotation: turn now sits at lane 3, so lane 3 beats lane 0.
      lane_val[0] = 16'd200; lane_left[0] = 4;
      lane_val[3] = 16'd300; lane_left[3] = 4;
      obs_q.delete();
      drive();
      repeat (16) step();
      check_srcs("rot", 4, 3, 0);

      // Reset mid-burst on lane 1 after two beats.
      lane_val[1] = 16'd400; lane_left[1] = 4;
      drive();
      n = 0;
      while (!(m_serving && m_lane == 1 && m_beats == 2) && n < 20) begin
         step();
         n++;
      end
      check("midrst_reached", n < 20, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data",  out_data,  0);
      check("midrst_out_src",   out_src,   0);
      check("midrst_busy",      busy,      0);
      check("midrst_sel",       sel,       0);
      check("midrst_req_ready", req_ready, 0);
      model_reset();
      clear_lanes();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lane_val[0] = 16'd500; lane_left[0] = 4;
      lane_val[1] = 16'd600; lane_left[1] = 4;
      obs_q.delete();
      drive();
      repeat (14) step();
      check_srcs("postrst", 4, 0, 1);

      // All four continuously valid from a clean turn pointer.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         lane_val[i]  = 16'(1000 * (i + 1));
         lane_left[i] = 8;
      end
      obs_q.delete(); step_no = 0;
      drive();
      repeat (22) step();
      check("all_throughput", obs_q.size(), 16);
      repeat (8) step();
      for (int k = 0; k < 20 && k < obs_q.size(); k++) begin
         check("all_order", obs_q[k].src, (k / 4) % 4);
      end
      clear_lanes();
      drive();
      repeat (30) step();

      // Backpressure on lane 0 with a -5 sample held for three cycles.
      lane_val[0] = 16'hFFFB; lane_left[0] = 4;
      obs_q.delete();
      drive();
      n = 0;
      while (!(m_ov && m_od == 16'hFFFB) && n < 20) begin
         step();
         n++;
      end
      check("bp_reached", n < 20, 1);
      stall_cnt = 3;
      drive();
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_hold_data", out_data,  16'hFFFB);
         check("bp_hold_rdy",  req_ready, 0);
         step();
      end
      repeat (10) step();
      check("bp_count", obs_q.size(), 4);
      for (int k = 0; k < obs_q.size() && k < 4; k++) begin
         check("bp_data", obs_q[k].data, 16'hFFFB + 16'(k));
         check("bp_last", obs_q[k].last, k == 3);
      end

      // Randomized traffic: random gaps, random backpressure, random samples.
      do_reset();
      rand_data = 1; gate_pct = 70; ready_pct = 70;
      for (int i = 0; i < 4; i++) begin
         lane_val[i]  = 16'($urandom);
         lane_left[i] = 1000;
      end
      drive();
      repeat (400) step();
      clear_lanes(); ready_pct = 100;
      drive();
      repeat (20) step();

      // BURST=1 build: lanes 1 and 3 alternate, every beat is last.
      b1_req_valid = 4'b1010;
      b1_req_data  = '0;
      b1_req_data[1*DW +: DW] = 16'd111;
      b1_req_data[3*DW +: DW] = 16'd333;
      b1_out_ready = 1'b1;
      b1_seen = 0;
      repeat (16) begin
         @(negedge clk);
         if (b1_out_valid) begin
            b1_seen++;
            b1_src.push_back(int'(b1_out_src));
            check("b1_last", b1_out_last, 1);
            check("b1_data", b1_out_data, (b1_out_src == 2'd1) ? 16'd111 : 16'd333);
         end
      end
      check("b1_count", b1_seen >= 4, 1);
      for (int k = 0; k < 4 && k < b1_src.size(); k++) begin
         check("b1_order", b1_src[k], (k % 2 == 0) ? 1 : 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
